tb_svc_pulse_ctrl: RTL and testbench

Parametrised multi-channel testbench-service pulse/force controller for the Caliptra SS integration bench. It decodes mailbox-driven service commands and drives per-channel force-enable outputs (e.g. FC/LCC reset, escalation, zeroization strobes). Each output can be driven as:
- a one-shot pulse of programmable length;
- a held level;
- a periodic square wave.

Completion and error are reported back to the bench. It sits beside the existing tb-service decoder, which maps tb_service_cmd opcodes onto this block's command port.

---
 rtl/tb_svc_pulse_pkg.sv | 22 ++
 rtl/tb_svc_pulse_chan.sv | 121 ++++++++++++
 rtl/tb_svc_pulse_ctrl.sv | 86 ++++++++
 tb/tb_tb_svc_pulse_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_svc_pulse_pkg.sv
// rtl/tb_svc_pulse_pkg.sv - opcode and channel-state types for the tb-service pulse controller
package tb_svc_pulse_pkg;

  // Opcodes 6 and 7 are reserved and are deliberately left out of the enum.
  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_PULSE     = 3'd1,
    OP_ASSERT    = 3'd2,
    OP_RELEASE   = 3'd3,
    OP_PERIODIC  = 3'd4,
    OP_ABORT_ALL = 3'd5
  } tb_svc_op_e;

  typedef enum logic [2:0] {
    CH_IDLE    = 3'd0,
    CH_PULSE   = 3'd1,
    CH_HOLD    = 3'd2,
    CH_PER_ON  = 3'd3,
    CH_PER_OFF = 3'd4
  } tb_svc_ch_state_e;

endpackage

// File: rtl/tb_svc_pulse_chan.sv
// rtl/tb_svc_pulse_chan.sv - single force channel: pulse / hold / periodic FSM with length counter
module tb_svc_pulse_chan
  import tb_svc_pulse_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEF_LEN = 10
) (
  input  logic             clk,
  input  logic             cptra_rst,
  input  logic             pulse_cmd,
  input  logic             assert_cmd,
  input  logic             release_cmd,
  input  logic             periodic_cmd,
  input  logic             abort_cmd,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             force_en,
  output logic             busy,
  output logic             done,
  output logic             reject
);

  localparam logic [CNT_W-1:0] DEF_L = CNT_W'(DEF_LEN);

  tb_svc_ch_state_e state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] len_q, len_n;
  logic             done_n;
  logic             take;
  logic [CNT_W-1:0] eff_len;

  assign eff_len = (cmd_len == '0) ? DEF_L : cmd_len;

  // State, counter, periodic half-length and done strobe registers
  always_ff @(posedge clk) begin
    if (cptra_rst) begin
      state <= CH_IDLE;
      cnt   <= '0;
      len_q <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      len_q <= len_n;
      done  <= done_n;
    end
  end

  // Commands override the channel's own counting; a rejected command leaves it running
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len_q;
    done_n  = 1'b0;
    reject  = 1'b0;
    take    = 1'b0;
    if (abort_cmd || release_cmd) begin
      take    = 1'b1;
      state_n = CH_IDLE;
      cnt_n   = '0;
    end else if (pulse_cmd) begin
      if (state == CH_IDLE || state == CH_PULSE) begin
        take    = 1'b1;
        state_n = CH_PULSE;
        cnt_n   = eff_len - 1'b1;
      end else begin
        reject = 1'b1;
      end
    end else if (assert_cmd) begin
      if (state == CH_PER_ON || state == CH_PER_OFF) begin
        reject = 1'b1;
      end else begin
        take    = 1'b1;
        state_n = CH_HOLD;
        cnt_n   = '0;
      end
    end else if (periodic_cmd) begin
      if (state == CH_IDLE || state == CH_PULSE) begin
        take    = 1'b1;
        state_n = CH_PER_ON;
        cnt_n   = eff_len - 1'b1;
        len_n   = eff_len;
      end else begin
        reject = 1'b1;
      end
    end
    if (!take) begin
      case (state)
        CH_PULSE: begin
          if (cnt == '0) begin
            state_n = CH_IDLE;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        CH_PER_ON: begin
          if (cnt == '0) begin
            state_n = CH_PER_OFF;
            cnt_n   = len_q - 1'b1;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        CH_PER_OFF: begin
          if (cnt == '0) begin
            state_n = CH_PER_ON;
            cnt_n   = len_q - 1'b1;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign force_en = (state == CH_PULSE) || (state == CH_HOLD) || (state == CH_PER_ON);
  assign busy     = (state != CH_IDLE);

endmodule

// File: rtl/tb_svc_pulse_ctrl.sv
// rtl/tb_svc_pulse_ctrl.sv - multi-channel tb-service force controller: decode, range check, channels
module tb_svc_pulse_ctrl
  import tb_svc_pulse_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int DEF_LEN = 10,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              cptra_rst,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_op,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [CNT_W-1:0]  cmd_len,
  output logic [NUM_CH-1:0] force_o,
  output logic [NUM_CH-1:0] busy_o,
  output logic [NUM_CH-1:0] done_o,
  output logic              err_o
);

  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  tb_svc_op_e        op;
  logic              ch_ok;
  logic              op_pulse, op_assert, op_release, op_periodic, op_abort;
  logic              dec_err;
  logic [NUM_CH-1:0] rej;

  assign op    = tb_svc_op_e'(cmd_op);
  assign ch_ok = ({1'b0, cmd_ch} < NUM_CH_L);

  // Opcode decode; out-of-range channel or reserved opcode is a decode error
  always_comb begin
    op_pulse    = 1'b0;
    op_assert   = 1'b0;
    op_release  = 1'b0;
    op_periodic = 1'b0;
    op_abort    = 1'b0;
    dec_err     = 1'b0;
    if (cmd_valid) begin
      case (op)
        OP_NOP:       begin end
        OP_PULSE:     if (ch_ok) op_pulse    = 1'b1; else dec_err = 1'b1;
        OP_ASSERT:    if (ch_ok) op_assert   = 1'b1; else dec_err = 1'b1;
        OP_RELEASE:   if (ch_ok) op_release  = 1'b1; else dec_err = 1'b1;
        OP_PERIODIC:  if (ch_ok) op_periodic = 1'b1; else dec_err = 1'b1;
        OP_ABORT_ALL: op_abort = 1'b1;
        default:      dec_err = 1'b1;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = (cmd_ch == CH_W'(i));

    tb_svc_pulse_chan #(
      .CNT_W   (CNT_W),
      .DEF_LEN (DEF_LEN)
    ) u_chan (
      .clk          (clk),
      .cptra_rst    (cptra_rst),
      .pulse_cmd    (op_pulse    && sel),
      .assert_cmd   (op_assert   && sel),
      .release_cmd  (op_release  && sel),
      .periodic_cmd (op_periodic && sel),
      .abort_cmd    (op_abort),
      .cmd_len      (cmd_len),
      .force_en     (force_o[i]),
      .busy         (busy_o[i]),
      .done         (done_o[i]),
      .reject       (rej[i])
    );
  end

  // Error strobe is registered so it lands in the cycle after the offending command
  always_ff @(posedge clk) begin
    if (cptra_rst) begin
      err_o <= 1'b0;
    end else begin
      err_o <= dec_err | (|rej);
    end
  end

endmodule

// File: tb/tb_tb_svc_pulse_ctrl.sv
// tb/tb_tb_svc_pulse_ctrl.sv - directed self-checking bench for tb_svc_pulse_ctrl
module tb_tb_svc_pulse_ctrl;

  localparam int NUM_CH  = 6;
  localparam int CNT_W   = 8;
  localparam int DEF_LEN = 10;
  localparam int CH_W    = 3;

  logic              clk = 1'b0;
  logic              cptra_rst;
  logic              cmd_valid;
  logic [2:0]        cmd_op;
  logic [CH_W-1:0]   cmd_ch;
  logic [CNT_W-1:0]  cmd_len;
  logic [NUM_CH-1:0] force_o;
  logic [NUM_CH-1:0] busy_o;
  logic [NUM_CH-1:0] done_o;
  logic              err_o;

  int checks = 0;
  int fails  = 0;

  tb_svc_pulse_ctrl #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DEF_LEN (DEF_LEN)
  ) dut (
    .clk       (clk),
    .cptra_rst (cptra_rst),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ch    (cmd_ch),
    .cmd_len   (cmd_len),
    .force_o   (force_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input int ch, input int len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_ch    = CH_W'(ch);
    cmd_len   = CNT_W'(len);
  endtask

  task automatic idle_cmd();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_ch    = '0;
    cmd_len   = '0;
  endtask

  task automatic test_reset();
    cptra_rst = 1'b1;
    idle_cmd();
    cyc();
    cyc();
    checks++; if (force_o !== 6'b0) begin fails++; $display("FAIL reset_force got=%b exp=000000", force_o); end
    checks++; if (busy_o !== 6'b0) begin fails++; $display("FAIL reset_busy got=%b exp=000000", busy_o); end
    checks++; if (done_o !== 6'b0) begin fails++; $display("FAIL reset_done got=%b exp=000000", done_o); end
    checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err_o); end
    cptra_rst = 1'b0;
    cyc();
  endtask

  task automatic test_default_pulse();
    drive(3'd1, 0, 0);
    cyc();
    idle_cmd();
    for (int k = 1; k <= 10; k++) begin
      checks++; if (force_o[0] !== 1'b1) begin fails++; $display("FAIL defpulse_force cyc=%0d got=%b exp=1", k, force_o[0]); end
      checks++; if (done_o[0] !== 1'b0) begin fails++; $display("FAIL defpulse_done_early cyc=%0d got=%b exp=0", k, done_o[0]); end
      cyc();
    end
    checks++; if (force_o[0] !== 1'b0) begin fails++; $display("FAIL defpulse_force_end got=%b exp=0", force_o[0]); end
    checks++; if (done_o[0] !== 1'b1) begin fails++; $display("FAIL defpulse_done got=%b exp=1", done_o[0]); end
    checks++; if (busy_o[0] !== 1'b0) begin fails++; $display("FAIL defpulse_busy got=%b exp=0", busy_o[0]); end
    cyc();
    checks++; if (done_o[0] !== 1'b0) begin fails++; $display("FAIL defpulse_done_width got=%b exp=0", done_o[0]); end
  endtask

  task automatic test_retrigger();
    int hi, dn, first_low, dn_cyc;
    hi = 0; dn = 0; first_low = -1; dn_cyc = -1;
    drive(3'd1, 1, 5);
    cyc();
    idle_cmd();
    for (int k = 1; k <= 14; k++) begin
      if (force_o[1] === 1'b1) begin
        if (first_low < 0) hi++;
      end else if (first_low < 0) begin
        first_low = k;
      end
      if (done_o[1] === 1'b1) begin dn++; dn_cyc = k; end
      if (k == 2) drive(3'd1, 1, 8);
      cyc();
      idle_cmd();
    end
    checks++; if (hi !== 10) begin fails++; $display("FAIL retrig_high_cycles got=%0d exp=10", hi); end
    checks++; if (first_low !== 11) begin fails++; $display("FAIL retrig_first_low got=%0d exp=11", first_low); end
    checks++; if (dn !== 1) begin fails++; $display("FAIL retrig_done_count got=%0d exp=1", dn); end
    checks++; if (dn_cyc !== 11) begin fails++; $display("FAIL retrig_done_cycle got=%0d exp=11", dn_cyc); end
  endtask

  task automatic test_periodic();
    logic exp_f;
    drive(3'd4, 2, 3);
    cyc();
    idle_cmd();
    for (int k = 1; k <= 21; k++) begin
      exp_f = (((k - 1) / 3) % 2) == 0;
      checks++; if (force_o[2] !== exp_f) begin fails++; $display("FAIL periodic_force cyc=%0d got=%b exp=%b", k, force_o[2], exp_f); end
      checks++; if (done_o[2] !== 1'b0) begin fails++; $display("FAIL periodic_done cyc=%0d got=%b exp=0", k, done_o[2]); end
      cyc();
    end
    checks++; if (force_o[2] !== 1'b0 || busy_o[2] !== 1'b1) begin fails++; $display("FAIL periodic_off_phase force=%b busy=%b exp=0/1", force_o[2], busy_o[2]); end
    drive(3'd3, 2, 0);
    cyc();
    idle_cmd();
    checks++; if (busy_o[2] !== 1'b0 || force_o[2] !== 1'b0) begin fails++; $display("FAIL periodic_release busy=%b force=%b exp=0/0", busy_o[2], force_o[2]); end
    checks++; if (done_o[2] !== 1'b0) begin fails++; $display("FAIL periodic_release_done got=%b exp=0", done_o[2]); end
    cyc();
    checks++; if (force_o[2] !== 1'b0) begin fails++; $display("FAIL periodic_stays_idle got=%b exp=0", force_o[2]); end
  endtask

  task automatic test_errors();
    drive(3'd1, NUM_CH, 2);
    cyc();
    idle_cmd();
    checks++; if (err_o !== 1'b1) begin fails++; $display("FAIL err_badch got=%b exp=1", err_o); end
    checks++; if (busy_o !== 6'b0) begin fails++; $display("FAIL err_badch_state got=%b exp=000000", busy_o); end
    cyc();
    checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL err_badch_width got=%b exp=0", err_o); end
    drive(3'd6, 0, 2);
    cyc();
    idle_cmd();
    checks++; if (err_o !== 1'b1) begin fails++; $display("FAIL err_rsvd_op got=%b exp=1", err_o); end
    checks++; if (busy_o !== 6'b0) begin fails++; $display("FAIL err_rsvd_state got=%b exp=000000", busy_o); end
    cyc();
    checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL err_rsvd_width got=%b exp=0", err_o); end
    drive(3'd2, 3, 0);
    cyc();
    idle_cmd();
    checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL err_assert_ok got=%b exp=0", err_o); end
    checks++; if (force_o !== 6'b001000) begin fails++; $display("FAIL err_hold_force got=%b exp=001000", force_o); end
    drive(3'd1, 3, 2);
    cyc();
    idle_cmd();
    checks++; if (err_o !== 1'b1) begin fails++; $display("FAIL err_pulse_on_hold got=%b exp=1", err_o); end
    checks++; if (busy_o !== 6'b001000) begin fails++; $display("FAIL err_hold_busy got=%b exp=001000", busy_o); end
    cyc();
    checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL err_hold_width got=%b exp=0", err_o); end
    cyc(); cyc(); cyc();
    checks++; if (force_o !== 6'b001000 || done_o !== 6'b0) begin fails++; $display("FAIL err_hold_kept force=%b done=%b exp=001000/000000", force_o, done_o); end
    drive(3'd3, 3, 0);
    cyc();
    idle_cmd();
    checks++; if (busy_o !== 6'b0 || done_o !== 6'b0) begin fails++; $display("FAIL err_hold_release busy=%b done=%b exp=0/0", busy_o, done_o); end
  endtask

  task automatic setup_three();
    drive(3'd2, 0, 0);
    cyc();
    drive(3'd1, 1, 20);
    cyc();
    drive(3'd4, 2, 3);
    cyc();
    idle_cmd();
    cyc();
  endtask

  task automatic test_abort_reset();
    setup_three();
    checks++; if (busy_o !== 6'b000111) begin fails++; $display("FAIL abort_setup_busy got=%b exp=000111", busy_o); end
    checks++; if (force_o !== 6'b000111) begin fails++; $display("FAIL abort_setup_force got=%b exp=000111", force_o); end
    drive(3'd5, 5, 0);
    cyc();
    idle_cmd();
    checks++; if (force_o !== 6'b0 || busy_o !== 6'b0) begin fails++; $display("FAIL abort_clear force=%b busy=%b exp=0/0", force_o, busy_o); end
    checks++; if (done_o !== 6'b0 || err_o !== 1'b0) begin fails++; $display("FAIL abort_done done=%b err=%b exp=0/0", done_o, err_o); end
    cyc();
    checks++; if (done_o !== 6'b0 || busy_o !== 6'b0) begin fails++; $display("FAIL abort_after done=%b busy=%b exp=0/0", done_o, busy_o); end
    setup_three();
    cyc();
    cptra_rst = 1'b1;
    cyc();
    checks++; if (force_o !== 6'b0 || busy_o !== 6'b0) begin fails++; $display("FAIL rst_mid force=%b busy=%b exp=0/0", force_o, busy_o); end
    checks++; if (done_o !== 6'b0 || err_o !== 1'b0) begin fails++; $display("FAIL rst_mid_done done=%b err=%b exp=0/0", done_o, err_o); end
    cptra_rst = 1'b0;
    cyc();
    checks++; if (done_o !== 6'b0 || busy_o !== 6'b0) begin fails++; $display("FAIL rst_after done=%b busy=%b exp=0/0", done_o, busy_o); end
  endtask

  task automatic test_expiry_collision();
    drive(3'd1, 0, 4);
    cyc();
    idle_cmd();
    cyc(); cyc(); cyc();
    checks++; if (force_o[0] !== 1'b1) begin fails++; $display("FAIL collide_last_high got=%b exp=1", force_o[0]); end
    drive(3'd3, 0, 0);
    cyc();
    idle_cmd();
    checks++; if (force_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin fails++; $display("FAIL collide_idle force=%b busy=%b exp=0/0", force_o[0], busy_o[0]); end
    checks++; if (done_o[0] !== 1'b0) begin fails++; $display("FAIL collide_done got=%b exp=0", done_o[0]); end
    cyc();
    checks++; if (done_o[0] !== 1'b0) begin fails++; $display("FAIL collide_done_late got=%b exp=0", done_o[0]); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_f [1:6];
    logic [1:0] exp_d [1:6];
    exp_f[1] = 2'b01; exp_f[2] = 2'b11; exp_f[3] = 2'b10;
    exp_f[4] = 2'b10; exp_f[5] = 2'b00; exp_f[6] = 2'b00;
    exp_d[1] = 2'b00; exp_d[2] = 2'b00; exp_d[3] = 2'b01;
    exp_d[4] = 2'b00; exp_d[5] = 2'b10; exp_d[6] = 2'b00;
    drive(3'd1, 0, 2);
    cyc();
    drive(3'd1, 1, 3);
    for (int k = 1; k <= 6; k++) begin
      checks++; if (force_o[1:0] !== exp_f[k]) begin fails++; $display("FAIL b2b_force cyc=%0d got=%b exp=%b", k, force_o[1:0], exp_f[k]); end
      checks++; if (done_o[1:0] !== exp_d[k]) begin fails++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", k, done_o[1:0], exp_d[k]); end
      cyc();
      idle_cmd();
    end
  endtask

  initial begin
    cptra_rst = 1'b1;
    idle_cmd();
    test_reset();
    test_default_pulse();
    test_retrigger();
    test_periodic();
    test_errors();
    test_abort_reset();
    test_expiry_collision();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
